// File: rtl/lower_layer_2_0_seq.sv
// Initiator side of the lower-layer 2-element sort handshake: buffers entries in pairs,
// drives the sort unit, and emits sorted 2-entry runs (or a 1-entry run for an odd tail).
module lower_layer_2_0_seq #(
  parameter int DW = 16,
  parameter int LW = 4,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_dist,
  input  logic [LW-1:0]    in_label,
  input  logic             in_last,
  output logic             load,
  output logic [DW+LW-1:0] pair_a,
  output logic [DW+LW-1:0] pair_b,
  input  logic             done,
  input  logic [DW+LW-1:0] sorted_lo,
  input  logic [DW+LW-1:0] sorted_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_dist,
  output logic [LW-1:0]    out_label,
  output logic             out_run_last,
  output logic             out_frame_last,
  output logic [CW-1:0]    run_count
);

  localparam int EW = DW + LW;
  localparam logic [CW-1:0] RC_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FILL0, FILL1, LOAD, GUARD, WAIT, EMIT0, EMIT1, EMIT_S
  } state_t;

  state_t        state;
  logic [EW-1:0] out_hi;
  logic [EW-1:0] out_data;
  logic          frame_end;
  logic          rc_clear;
  logic          in_xfer;
  logic          out_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_dist  = out_data[EW-1:LW];
  assign out_label = out_data[LW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FILL0;
      in_ready       <= 1'b0;
      load           <= 1'b0;
      pair_a         <= '0;
      pair_b         <= '0;
      out_hi         <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_run_last   <= 1'b0;
      out_frame_last <= 1'b0;
      frame_end      <= 1'b0;
      run_count      <= '0;
      rc_clear       <= 1'b0;
    end else begin
      load     <= 1'b0;
      rc_clear <= 1'b0;
      // The frame-final run count stays visible for one cycle before clearing.
      if (rc_clear) run_count <= '0;
      case (state)
        FILL0: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            pair_a <= {in_dist, in_label};
            if (in_last) begin
              in_ready       <= 1'b0;
              out_data       <= {in_dist, in_label};
              out_valid      <= 1'b1;
              out_run_last   <= 1'b1;
              out_frame_last <= 1'b1;
              state          <= EMIT_S;
            end else begin
              state <= FILL1;
            end
          end
        end
        FILL1: begin
          if (in_xfer) begin
            pair_b    <= {in_dist, in_label};
            frame_end <= in_last;
            in_ready  <= 1'b0;
            load      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD:  state <= GUARD;
        // done may still reflect the previous pair here, so it is not looked at.
        GUARD: state <= WAIT;
        WAIT: begin
          if (done) begin
            out_hi         <= sorted_hi;
            out_data       <= sorted_lo;
            out_valid      <= 1'b1;
            out_run_last   <= 1'b0;
            out_frame_last <= 1'b0;
            state          <= EMIT0;
          end
        end
        EMIT0: begin
          if (out_xfer) begin
            out_data       <= out_hi;
            out_run_last   <= 1'b1;
            out_frame_last <= frame_end;
            state          <= EMIT1;
          end
        end
        EMIT1: begin
          if (out_xfer) begin
            out_valid      <= 1'b0;
            out_run_last   <= 1'b0;
            out_frame_last <= 1'b0;
            run_count      <= run_count + RC_ONE;
            rc_clear       <= frame_end;
            in_ready       <= 1'b1;
            state          <= FILL0;
          end
        end
        EMIT_S: begin
          if (out_xfer) begin
            out_valid      <= 1'b0;
            out_run_last   <= 1'b0;
            out_frame_last <= 1'b0;
            run_count      <= run_count + RC_ONE;
            rc_clear       <= 1'b1;
            in_ready       <= 1'b1;
            state          <= FILL0;
          end
        end
        default: state <= FILL0;
      endcase
    end
  end

endmodule

// File: tb/tb_lower_layer_2_0_seq.sv
// Randomized bench for lower_layer_2_0_seq: a behavioural sort unit plus a queue-based
// model of the expected run stream, with directed reset, stale-done and backpressure cases.
module tb_lower_layer_2_0_seq;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int CW = 2;
  localparam int EW = DW + LW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dist;
  logic [LW-1:0] in_label;
  logic          in_last;
  logic          load;
  logic [EW-1:0] pair_a, pair_b;
  logic          done;
  logic [EW-1:0] sorted_lo, sorted_hi;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_dist;
  logic [LW-1:0] out_label;
  logic          out_run_last;
  logic          out_frame_last;
  logic [CW-1:0] run_count;

  lower_layer_2_0_seq #(.DW(DW), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .in_label(in_label),
    .in_last(in_last), .load(load), .pair_a(pair_a), .pair_b(pair_b), .done(done),
    .sorted_lo(sorted_lo), .sorted_hi(sorted_hi), .out_valid(out_valid),
    .out_ready(out_ready), .out_dist(out_dist), .out_label(out_label),
    .out_run_last(out_run_last), .out_frame_last(out_frame_last), .run_count(run_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural sort unit: done drops one cycle after load is seen, rises after a delay.
  int   done_delay = 2;
  logic stall_done = 1'b0;
  logic load_seen;
  int   cnt;
  int   loads_seen;
  logic [EW-1:0] sa, sb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0; load_seen <= 1'b0; cnt <= 0; loads_seen <= 0;
      sa <= '0; sb <= '0; sorted_lo <= '0; sorted_hi <= '0;
    end else begin
      load_seen <= load;
      if (load) begin
        sa <= pair_a; sb <= pair_b; loads_seen <= loads_seen + 1;
      end
      if (load_seen) begin
        done <= 1'b0;
        cnt  <= (done_delay > 0) ? done_delay : int'($urandom_range(1, 4));
      end else if (cnt > 0 && !stall_done) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          done      <= 1'b1;
          sorted_lo <= (sa[EW-1:LW] <= sb[EW-1:LW]) ? sa : sb;
          sorted_hi <= (sa[EW-1:LW] <= sb[EW-1:LW]) ? sb : sa;
        end
      end
    end
  end

  // Reference model: the input stream regrouped into ascending runs.
  typedef struct packed {
    logic [EW-1:0] e;
    logic          rl;
    logic          fl;
  } exp_t;
  exp_t          exp_q[$];
  logic          have_pend = 1'b0;
  logic [EW-1:0] pend;
  int            pairs_sent = 0;

  task automatic model_push(input logic [EW-1:0] e, input logic last);
    if (!have_pend) begin
      if (last) exp_q.push_back('{e, 1'b1, 1'b1});
      else begin
        pend = e; have_pend = 1'b1;
      end
    end else begin
      if (pend[EW-1:LW] <= e[EW-1:LW]) begin
        exp_q.push_back('{pend, 1'b0, 1'b0}); exp_q.push_back('{e, 1'b1, last});
      end else begin
        exp_q.push_back('{e, 1'b0, 1'b0}); exp_q.push_back('{pend, 1'b1, last});
      end
      have_pend = 1'b0;
      pairs_sent++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic last);
    bit ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_dist = d; in_label = l; in_last = last;
    for (int k = 0; k < 300; k++) begin
      if (in_ready) begin
        ok = 1; break;
      end
      @(negedge clk);
    end
    if (ok) begin
      model_push({d, l}, last);
      $display("[TB] in  dist=%0d label=%0d last=%0b", d, l, last);
      @(posedge clk);
      #1;
    end else begin
      check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Output monitor: drives out_ready, checks data, hold stability and run_count.
  int            bp_mode = 0;
  bit            bp_arm = 0;
  int            stall_left = 0;
  bit            held_pending = 0;
  logic [EW-1:0] held_e;
  logic [1:0]    held_f;
  int            rc_model = 0;
  int            rc_chk = -1;
  bit            rc_then_zero = 0;
  bit            rc_zero = 0;

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      held_pending = 0; rc_chk = -1; rc_zero = 0; rc_then_zero = 0; rc_model = 0; stall_left = 0;
    end else begin
      if (rc_zero) begin
        check_eq("run_count_clear", {30'd0, run_count}, 0);
        rc_zero = 0;
      end
      if (rc_chk >= 0) begin
        check_eq("run_count", {30'd0, run_count}, rc_chk);
        rc_zero = rc_then_zero; rc_chk = -1;
      end
      if (held_pending) begin
        check_eq("hold_valid", {31'd0, out_valid}, 1);
        check_eq("hold_data", {12'd0, out_dist, out_label}, {12'd0, held_e});
        check_eq("hold_flags", {30'd0, out_run_last, out_frame_last}, {30'd0, held_f});
      end
      if (out_valid) check_eq("in_ready_busy", {31'd0, in_ready}, 0);
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else if (bp_arm && out_valid) begin
        out_ready = 1'b0; stall_left = 4; bp_arm = 0;
      end else begin
        out_ready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) begin
        held_pending = 0;
        if (exp_q.size() == 0) begin
          check_eq("out_spurious", {31'd0, out_valid}, 0);
        end else begin
          x = exp_q.pop_front();
          $display("[TB] out dist=%0d label=%0d run_last=%0b frame_last=%0b",
                   out_dist, out_label, out_run_last, out_frame_last);
          check_eq("out_data", {12'd0, out_dist, out_label}, {12'd0, x.e});
          check_eq("out_run_last", {31'd0, out_run_last}, {31'd0, x.rl});
          check_eq("out_frame_last", {31'd0, out_frame_last}, {31'd0, x.fl});
          if (x.rl) begin
            rc_model     = (rc_model + 1) % (1 << CW);
            rc_chk       = rc_model;
            rc_then_zero = x.fl;
            if (x.fl) rc_model = 0;
          end
        end
      end else begin
        held_pending = out_valid;
        held_e       = {out_dist, out_label};
        held_f       = {out_run_last, out_frame_last};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_dist = '0; in_label = '0; in_last = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    check_eq("rst_load", {31'd0, load}, 0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 0);
    check_eq("rst_flags", {30'd0, out_run_last, out_frame_last}, 0);
    check_eq("rst_pair_a", {12'd0, pair_a}, 0);
    check_eq("rst_pair_b", {12'd0, pair_b}, 0);
    check_eq("rst_run_count", {30'd0, run_count}, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    #1 check_eq("in_ready_after_release", {31'd0, in_ready}, 0);
    @(posedge clk); #1 check_eq("in_ready_up", {31'd0, in_ready}, 1);

    // Basic pair, done two cycles after it drops.
    done_delay = 2;
    send(16'd9, 4'd1, 1'b0);
    send(16'd3, 4'd2, 1'b0);
    drain();
    check_eq("loads_pair", loads_seen, pairs_sent);

    // Odd frame: one pair then a single trailing entry; done returns fast (stale-done path).
    done_delay = 1;
    send(16'd5, 4'd0, 1'b0);
    send(16'd1, 4'd1, 1'b0);
    send(16'd7, 4'd2, 1'b1);
    drain();

    // Backpressure for 5 cycles in EMIT0.
    bp_arm = 1;
    send(16'd20, 4'd7, 1'b0);
    send(16'd10, 4'd6, 1'b1);
    drain();
    check_eq("loads_bp", loads_seen, pairs_sent);

    // Reset while waiting on a done that never comes.
    stall_done = 1'b1;
    send(16'd11, 4'd5, 1'b0);
    send(16'd6, 4'd4, 1'b0);
    for (int k = 0; k < 50 && !load; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("wait_no_out", {31'd0, out_valid}, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_load", {31'd0, load}, 0);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 0);
    exp_q.delete(); have_pend = 1'b0; pairs_sent = 0; stall_done = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    send(16'd4, 4'd3, 1'b0);
    send(16'd2, 4'd1, 1'b1);
    drain();

    // run_count wrap: five pairs with no frame end.
    for (int p = 0; p < 10; p++) send(16'($urandom_range(0, 99)), 4'($urandom_range(0, 15)), 1'b0);
    drain();

    // Randomized traffic with random done latency and out_ready.
    done_delay = 0; bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(16'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
           (i == 149) ? 1'b1 : 1'($urandom_range(0, 7) == 0));
    end
    drain();
    check_eq("loads_total", loads_seen, pairs_sent);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
